// File: rtl/enc_if.sv
// Bus interface for the SECDED encoder: raw data word in, registered codeword out.
interface enc_if;
  logic [127:0] IN;   // data word to encode, sampled every rising edge
  logic [136:0] OUT;  // registered SECDED codeword

  // Producer side: drives the data word, observes the codeword.
  modport master (
    output IN,
    input  OUT
  );

  // Encoder side: consumes the data word, drives the codeword.
  modport slave (
    input  IN,
    output OUT
  );
endinterface : enc_if

// File: rtl/enc_top.sv
// SECDED Hamming encoder, 128 data bits -> 137-bit codeword.
//
// Codeword layout (bit k of OUT is codeword position k):
//   position 0              overall even parity P over positions 1..136
//   positions 2^i, i=0..7   Hamming check bit Ci
//   all other positions     data bits, IN[0] at position 3, ascending
//
// The encode is a pure XOR network; only its result is registered, giving one
// cycle of latency and one codeword per cycle with no handshake.
module enc_top (
  input  logic        clk,
  input  logic        rst,
  enc_if.slave        bus
);

  localparam int unsigned DATA_W  = 128;
  localparam int unsigned CODE_W  = 137;
  localparam int unsigned CHECK_N = 8;
  localparam int unsigned LAST_POS = CODE_W - 1;

  // True when a codeword position carries a check bit (a power of two).
  function automatic logic is_check_pos(input int unsigned pos);
    return (pos != 0) && ((pos & (pos - 1)) == 0);
  endfunction

  logic [CODE_W-1:0] code_d;
  logic [CODE_W-1:0] out_q;

  // Scatter data bits into their positions, then fill the check bits and P.
  always_comb begin
    int unsigned data_idx;
    logic        chk;

    // NOTE: every variable assigned here gets a value before any condition,
    // so no path leaves it holding a previous value and no latch is inferred.
    code_d   = '0;
    data_idx = 0;
    chk      = 1'b0;

    // Data bits occupy the non-power-of-two positions in ascending order.
    for (int unsigned pos = 1; pos <= LAST_POS; pos++) begin
      if (!is_check_pos(pos)) begin
        code_d[8'(pos)] = bus.IN[7'(data_idx)];
        data_idx++;
      end
    end

    // Ci covers every data-bearing position whose index has bit i set.
    for (int unsigned i = 0; i < CHECK_N; i++) begin
      chk = 1'b0;
      for (int unsigned pos = 3; pos <= LAST_POS; pos++) begin
        if (!is_check_pos(pos) && (((pos >> i) & 1) != 0)) begin
          chk = chk ^ code_d[8'(pos)];
        end
      end
      code_d[8'(1 << i)] = chk;
    end

    // P makes the full 137-bit word even parity, enabling double-error detect.
    code_d[0] = ^code_d[CODE_W-1:1];
  end

  // Output register: synchronous reset clears to the all-zero codeword.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples values from before the edge, independent of statement order.
    if (rst) begin
      out_q <= '0;
    end else begin
      out_q <= code_d;
    end
  end

  assign bus.OUT = out_q;

endmodule : enc_top

// File: tb/tb_enc_top.sv
// Directed and random checks for the SECDED encoder enc_top.
module tb_enc_top;

  logic clk;
  logic rst;
  enc_if bus ();

  enc_top dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_fail;
  int pos_of [128];  // codeword position of each data bit

  task automatic check(input string tag, input logic [136:0] got,
                       input logic [136:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: check bits equal the XOR of the position indices of all set
  // data bits (the syndrome of the data-only word).
  function automatic logic [136:0] model(input logic [127:0] d);
    logic [136:0] c;
    logic [7:0]   syn;
    c   = '0;
    syn = '0;
    for (int i = 0; i < 128; i++) begin
      if (d[i]) begin
        c[pos_of[i]] = 1'b1;
        syn = syn ^ 8'(pos_of[i]);
      end
    end
    for (int b = 0; b < 8; b++) c[1 << b] = syn[b];
    c[0] = ^c[136:1];
    return c;
  endfunction

  // Apply one word for one rising edge, then sample 1 time unit after it.
  task automatic step(input logic [127:0] d, input logic r);
    @(negedge clk);
    bus.IN = d;
    rst    = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] d;
    logic [136:0] exp;
    int           k;
    int           pc;
    int           p;

    n_checks = 0;
    n_fail   = 0;

    // Data positions: skip powers of two, ascending from 3.
    k = 0;
    for (int q = 3; q <= 136; q++) begin
      if ((q & (q - 1)) != 0) begin
        pos_of[k] = q;
        k++;
      end
    end

    rst    = 1'b1;
    bus.IN = '0;

    // Reset held for two edges with random data on the input.
    step(rnd128(), 1'b1);
    check("reset_edge0", bus.OUT, 137'd0);
    step(rnd128(), 1'b1);
    check("reset_edge1", bus.OUT, 137'd0);
    step(128'd0, 1'b0);
    check("zero_word", bus.OUT, 137'd0);

    // Hand-computed small values.
    step(128'd1, 1'b0);
    check("in_1", bus.OUT, 137'h0F);
    step(128'd2, 1'b0);
    check("in_2", bus.OUT, 137'h33);
    step(128'd3, 1'b0);
    check("in_3", bus.OUT, 137'h3C);

    // Top data bit lands at position 136 = 128 + 8.
    d = '0;
    d[127] = 1'b1;
    exp = '0;
    exp[0] = 1'b1; exp[8] = 1'b1; exp[128] = 1'b1; exp[136] = 1'b1;
    step(d, 1'b0);
    check("top_bit", bus.OUT, exp);

    // Walking ones: check bits spell out the position index.
    for (int i = 0; i < 128; i++) begin
      d = '0;
      d[i] = 1'b1;
      p   = pos_of[i];
      exp = '0;
      exp[p] = 1'b1;
      pc = 0;
      for (int b = 0; b < 8; b++) begin
        if (((p >> b) & 1) != 0) begin
          exp[1 << b] = 1'b1;
          pc++;
        end
      end
      exp[0] = 1'((1 + pc) % 2);
      step(d, 1'b0);
      check($sformatf("walk_%0d", i), bus.OUT, exp);
    end

    // Back-to-back random stream against the model, plus even parity.
    for (int i = 0; i < 10000; i++) begin
      d = rnd128();
      step(d, 1'b0);
      check("rand_word", bus.OUT, model(d));
      check("rand_parity", {136'd0, ^bus.OUT}, 137'd0);
    end

    // Reset for a single edge in the middle of a stream.
    for (int i = 0; i < 20; i++) begin
      d = rnd128();
      step(d, 1'b0);
      check("pre_rst_word", bus.OUT, model(d));
    end
    step(rnd128(), 1'b1);
    check("mid_rst", bus.OUT, 137'd0);
    d = rnd128();
    step(d, 1'b0);
    check("post_rst_word", bus.OUT, model(d));
    d = rnd128();
    step(d, 1'b0);
    check("post_rst_word2", bus.OUT, model(d));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule : tb_enc_top

// File: doc/enc_top.md
# enc_top

Single-error-correct / double-error-detect (SECDED) Hamming encoder for a 128-bit data word. Produces a 137-bit codeword: 128 data bits, 8 Hamming check bits and 1 overall parity bit. It sits on the write path ahead of protected storage. A decoder elsewhere in the design consumes the same bit layout. The datapath is combinational, followed by a single output register stage.

## Interface
- No parameters; widths fixed at 128 data bits and 137 codeword bits.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- IN  input  128  data word to encode; sampled every rising edge.
- OUT  output  137  registered SECDED codeword.

## Operation
- Codeword position k maps to OUT[k], for k = 0..136.
- Position 0 holds the overall parity bit P.
- Positions 1..136 form the Hamming codeword:
  - Check bits C0..C7 sit at the power-of-two positions 1, 2, 4, 8, 16, 32, 64, 128.
  - Data bits fill the remaining 128 positions in ascending order: IN[0]→3, IN[1]→5, IN[2]→6, IN[3]→7, IN[4]→9, …, IN[119]→127, IN[120]→129, …, IN[127]→136.
- Check bit Ci at position 2^i is the XOR of all data-bearing positions j (1..136) whose binary index has bit i set.
- P is the XOR of OUT[136:1]. The XOR of all 137 OUT bits is therefore always 0 (even parity).
- The encoder is a purely combinational XOR network from IN. Only its result is registered.
- There is no handshake and no valid signal: a new word is encoded every cycle, back-to-back, without stalls.
- All-zero data encodes to the all-zero codeword, so the reset value of OUT is itself a valid codeword.
- Any single data bit at position j sets exactly popcount(j) check bits. P then equals (1 + popcount(j)) mod 2.

## Timing
- Latency: 1 cycle. IN sampled at rising edge N appears on OUT after edge N and holds until edge N+1.
- Throughput: 1 codeword per cycle.
- Reset behaviour:
  - If rst=1 at a rising edge, OUT <= 137'd0. Reset has priority over IN.
  - OUT remains 0 for as many edges as rst is held.
  - On the first edge with rst=0, OUT takes encode(IN) for the IN present at that edge.
- Reset asserted mid-stream: the word presented on that edge is discarded, not encoded. There is no other internal state to clear.
- OUT before the first reset edge is undefined.
- X/Z on IN propagates. There is no input sanitising.
- Combinational depth: at most a 68-input XOR per check bit plus the P reduction. It must close timing at the system clock in one cycle.

## Test plan
- Reset then zero:
  - Hold rst=1 for 2 edges with IN=random → OUT=137'd0 each cycle.
  - Release with IN=0 → OUT=137'd0.
- Small values, each checked one cycle after it is applied:
  - IN=1 → OUT=137'h0F (bits 0, 1, 2, 3).
  - IN=2 → OUT=137'h33 (bits 0, 1, 4, 5).
  - IN=3 → OUT=137'h3C (bits 2, 3, 4, 5).
- Top bit: IN=1<<127 (data at position 136) → OUT has bits 0, 8, 128, 136 set; all others 0.
- Walking ones:
  - For each i in 0..127, IN=1<<i → exactly one data bit set at its mapped position.
  - Check bits equal the binary index of that position; OUT bit 0 = (1 + popcount(pos)) mod 2.
- Random stream: at least 10k back-to-back random words, no idle cycles. Compare against a reference model with 1-cycle latency. Every OUT must have XOR-reduction 0.
- Reset mid-stream: assert rst for one edge during a random stream.
  - That cycle: OUT=0.
  - Next cycle: OUT = encode of IN at the release edge, with no stale word.
